fence_t_seq: RTL and testbench
==============================

Name: fence_t_seq

Overview:
Parametrised microreset sequencer for fence.t, successor to the single-cache flush controller FSM. Drives NUM_CH independent flush req/ack channels (dcache, icache, TLBs, BTB, ...) in parallel or in strict index order. Pads completion to the next timer-interrupt boundary, then pulses a programmable-length uarch clear. Sits next to the flush controller; its halt output is ORed into the commit-stage halt.

Parameters:
NUM_CH, 2, number of flush channels (1..8)
SEQUENTIAL, 0, 0 = all channel requests issued together; 1 = one channel at a time, index 0 first
CNT_W, 32, width of pad counter, pad_i and ceil_o
CLR_CYCLES, 16, clear-pulse length in cycles (>=1)
INIT_HOLD, 3, cycles init_no_o stays high after clear ends (>=1)
VLEN, riscv::VLEN, address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
clr_i  in  1  synchronous clear; same effect as reset
fence_t_i  in  1  start pulse from commit
pc_commit_i  in  VLEN  PC of the fence.t instruction
boot_addr_i  in  VLEN  reset value of rst_addr_o
rst_addr_o  out  VLEN  fetch address after microreset
ch_en_i  in  NUM_CH  per-channel enable (CSR); disabled channels are skipped
flush_req_o  out  NUM_CH  flush request, level
flush_ack_i  in  NUM_CH  flush done, single-cycle pulse
busy_i  in  NUM_CH  channel has outstanding external handshakes
time_irq_i  in  1  timer interrupt level
pad_i  in  CNT_W  pad cycles relative to timer irq
ceil_o  out  CNT_W  remaining pad at flush completion
ceil_valid_o  out  1  one-cycle strobe qualifying ceil_o
halt_o  out  1  stall commit while not IDLE
clr_o  out  1  microarchitectural clear
init_no_o  out  1  suppress cache init
busy_o  out  1  FSM not IDLE

Behaviour:
- Reset/clr_i: FSM IDLE; all outputs 0 except rst_addr_o = boot_addr_i; pad counter 0; ack-done vector 0.
- IDLE: on fence_t_i, rst_addr_q <= pc_commit_i + 4 (wraps modulo 2^VLEN), go FLUSH. Output halt_o goes high the next cycle. fence_t_i in any other state is ignored.
- FLUSH, parallel mode: flush_req_o[i] = ch_en_i[i] & ~done[i], registered; first assertion is the cycle after entry.
- FLUSH, sequential mode: only the lowest-index enabled, not-done channel requests.
- A channel's done bit is set on flush_ack_i[i] while its req is high; acks to non-requesting channels are ignored.
- Req drops the cycle after the ack.
- Exit FLUSH when every enabled channel is done. ch_en_i == 0 exits after one cycle.
- ch_en_i is sampled on entry to FLUSH; later changes have no effect.
- Exit FLUSH -> DRAIN. On the transition, ceil_valid_o=1 and ceil_o = (pad_cnt==0) ? 0 : pad_i - pad_cnt, computed in the same cycle.
- DRAIN: go to CLR when busy_i==0 across all channels and pad_cnt==0.
- CLR: clr_o=1 for exactly CLR_CYCLES cycles (internal counter), then IDLE.
- init_no_o is high during CLR and for INIT_HOLD cycles after it.
- Pad counter:
  - On a rising edge of time_irq_i (registered previous value), load pad_i.
  - Otherwise, if nonzero, decrement by 1; stops at 0.
  - Load wins over decrement.
  - Runs in every state.
  - pad_i==0 on load: counter stays 0.
- halt_o = busy_o = (state != IDLE).
- clr_o does not reset this block, so the block itself survives its own clear pulse.
- Async reset mid-sequence aborts: reqs drop immediately and no clr_o is issued.

Decomposition:
- ariane_pkg: fence_t_state_e {IDLE, FLUSH, DRAIN, CLR}.
- Sub-module: reuse common_cells counter for the pad timer (load/down, WIDTH=CNT_W).
- Lowest-set-bit select for sequential mode stays inline (lzc from common_cells acceptable).

Test Plan:
- Parallel basic: NUM_CH=2, ch_en=2'b11, pc=0x8000_0100.
  - Acks at cycles +3 and +5 -> both reqs high from cycle +1; req[0] drops at +4, req[1] at +6.
  - clr_o high 16 cycles; rst_addr_o = 0x8000_0104; init_no_o low 3 cycles after clr_o falls.
- Sequential order: SEQUENTIAL=1, ch_en=2'b11.
  - req[1] stays 0 until the cycle after ack[0].
  - A spurious ack[1] during ch0's flush is ignored; req[1] still asserts afterwards.
- Padding: pad_i=100, irq rising edge, flush done 40 cycles later.
  - ceil_valid_o pulse with ceil_o=40.
  - CLR is entered only after pad_cnt reaches 0, about 60 cycles later.
- Busy drain: busy_i[0] held high 10 cycles after all acks -> remains in DRAIN 10 cycles; clr_o starts the cycle after busy_i falls.
- Skipped channels: ch_en=0 -> FLUSH lasts 1 cycle, no req asserted, CLR follows.
- Reset/clear: rst_ni low during FLUSH -> reqs drop immediately, rst_addr_o=boot_addr_i, no clr_o; clr_i during CLR -> IDLE next cycle.

Source files
------------

// File: rtl/fence_t_seq_pkg.sv
// fence.t microreset sequencer: shared types and helpers.
// Channel count is bounded by MAX_CH.
package fence_t_seq_pkg;

    localparam int unsigned MAX_CH   = 8;
    localparam int unsigned DEF_VLEN = 64;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        DRAIN,
        CLR
    } fence_t_state_e;

    // isolate the lowest set bit (v & -v)
    function automatic logic [MAX_CH-1:0] lsb_onehot(
        input logic [MAX_CH-1:0] v
    );
        lsb_onehot = v & (~v + MAX_CH'(1));
    endfunction

endpackage

// File: rtl/fence_t_seq_if.sv
// Flush channel bundle between the sequencer and
// the cache/TLB/BTB flush engines.
interface fence_t_seq_if #(
    parameter int unsigned NUM_CH = 2
);
    logic [NUM_CH-1:0] flush_req;
    logic [NUM_CH-1:0] flush_ack;
    logic [NUM_CH-1:0] busy;

    modport master (
        output flush_req,
        input  flush_ack,
        input  busy
    );

    modport slave (
        input  flush_req,
        output flush_ack,
        output busy
    );
endinterface

// File: rtl/fence_t_seq_cnt.sv
// Load/down pad timer; saturates at zero, load wins.
module fence_t_seq_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q <= '0;
        end else if (clr_i) begin
            r_q <= '0;
        end else if (load_i) begin
            r_q <= d_i;
        end else if (r_q != '0) begin
            r_q <= r_q - WIDTH'(1);
        end
    end

    assign q_o = r_q;
endmodule

// File: rtl/fence_t_seq.sv
// fence.t sequencer: flush channels, pad to timer
// boundary, drain, then pulse the uarch clear.
module fence_t_seq
    import fence_t_seq_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned SEQUENTIAL = 0,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned CLR_CYCLES = 16,
    parameter int unsigned INIT_HOLD  = 3,
    parameter int unsigned VLEN       = DEF_VLEN
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              fence_t_i,
    input  logic [VLEN-1:0]   pc_commit_i,
    input  logic [VLEN-1:0]   boot_addr_i,
    output logic [VLEN-1:0]   rst_addr_o,
    input  logic [NUM_CH-1:0] ch_en_i,
    fence_t_seq_if.master     ch,
    input  logic              time_irq_i,
    input  logic [CNT_W-1:0]  pad_i,
    output logic [CNT_W-1:0]  ceil_o,
    output logic              ceil_valid_o,
    output logic              halt_o,
    output logic              clr_o,
    output logic              init_no_o,
    output logic              busy_o
);
    localparam int unsigned CCW =
        (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam int unsigned HW = $clog2(INIT_HOLD + 1);
    localparam logic [CCW-1:0] CLR_LAST =
        CCW'(CLR_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(INIT_HOLD);

    fence_t_state_e    r_state;
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_done;
    logic [NUM_CH-1:0] r_req;
    logic [VLEN-1:0]   r_addr;
    logic              r_addr_vld;
    logic [CCW-1:0]    r_clr_cnt;
    logic [HW-1:0]     r_hold;
    logic              r_irq_q;

    logic [NUM_CH-1:0] w_done_nxt;
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_sel;
    logic [NUM_CH-1:0] w_entry_sel;
    logic              w_all_done;
    logic              w_exit;
    logic              w_irq_rise;
    logic              w_clr;
    logic [CNT_W-1:0]  w_cnt;

    assign w_irq_rise = time_irq_i & ~r_irq_q;

    fence_t_seq_cnt #(
        .WIDTH (CNT_W)
    ) u_pad_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .load_i (w_irq_rise),
        .d_i    (pad_i),
        .q_o    (w_cnt)
    );

    // an ack only counts while that channel is requesting
    assign w_done_nxt = r_done | (ch.flush_ack & r_req);
    assign w_pend     = r_en & ~w_done_nxt;
    assign w_all_done = (w_pend == '0);
    assign w_exit     = (r_state == FLUSH) & w_all_done;

    assign w_sel = (SEQUENTIAL != 0)
        ? NUM_CH'(lsb_onehot(MAX_CH'(w_pend)))
        : w_pend;
    assign w_entry_sel = (SEQUENTIAL != 0)
        ? NUM_CH'(lsb_onehot(MAX_CH'(ch_en_i)))
        : ch_en_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_en       <= '0;
            r_done     <= '0;
            r_req      <= '0;
            r_addr     <= '0;
            r_addr_vld <= 1'b0;
            r_clr_cnt  <= '0;
            r_hold     <= '0;
            r_irq_q    <= 1'b0;
        end else if (clr_i) begin
            r_state    <= IDLE;
            r_en       <= '0;
            r_done     <= '0;
            r_req      <= '0;
            r_addr     <= '0;
            r_addr_vld <= 1'b0;
            r_clr_cnt  <= '0;
            r_hold     <= '0;
            r_irq_q    <= 1'b0;
        end else begin
            r_irq_q <= time_irq_i;
            if (r_hold != '0) begin
                r_hold <= r_hold - HW'(1);
            end
            unique case (r_state)
                IDLE: begin
                    if (fence_t_i) begin
                        r_state    <= FLUSH;
                        r_addr     <= pc_commit_i + VLEN'(4);
                        r_addr_vld <= 1'b1;
                        r_en       <= ch_en_i;
                        r_done     <= '0;
                        r_req      <= w_entry_sel;
                    end
                end
                FLUSH: begin
                    r_done <= w_done_nxt;
                    r_req  <= w_sel;
                    if (w_all_done) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ch.busy == '0 && w_cnt == '0) begin
                        r_state   <= CLR;
                        r_clr_cnt <= '0;
                    end
                end
                CLR: begin
                    if (r_clr_cnt == CLR_LAST) begin
                        r_state <= IDLE;
                        r_hold  <= HOLD_LD;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + CCW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_clr         = (r_state == CLR);
    assign ch.flush_req  = r_req;
    assign rst_addr_o    = r_addr_vld ? r_addr : boot_addr_i;
    assign halt_o        = (r_state != IDLE);
    assign busy_o        = (r_state != IDLE);
    assign clr_o         = w_clr;
    assign init_no_o     = w_clr | (r_hold != '0);
    assign ceil_valid_o  = w_exit;
    assign ceil_o        = (w_exit && w_cnt != '0)
                           ? pad_i - w_cnt : '0;
endmodule

// File: tb/tb_fence_t_seq.sv
// Bench for fence_t_seq: parallel and sequential instances
// against a cycle-level behavioural model, plus literal pins.
module tb_fence_t_seq;
    localparam int CLRN = 16;
    localparam int HOLD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        fence = 1'b0;
    logic        irq = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] boot = 32'h0000_1000;
    logic [31:0] pad = '0;
    logic [1:0]  en = '0;
    logic [1:0]  ack [2];
    logic [1:0]  bz  [2];

    logic [31:0] o_addr [2];
    logic [31:0] o_ceil [2];
    logic        o_cv   [2];
    logic        o_halt [2];
    logic        o_clr  [2];
    logic        o_ino  [2];
    logic        o_busy [2];
    logic [1:0]  o_req  [2];

    fence_t_seq_if #(.NUM_CH(2)) if_p ();
    fence_t_seq_if #(.NUM_CH(2)) if_s ();

    assign if_p.flush_ack = ack[0];
    assign if_p.busy      = bz[0];
    assign if_s.flush_ack = ack[1];
    assign if_s.busy      = bz[1];
    assign o_req[0]       = if_p.flush_req;
    assign o_req[1]       = if_s.flush_req;

    always #5 clk = ~clk;

    fence_t_seq #(
        .NUM_CH(2), .SEQUENTIAL(0), .CNT_W(32),
        .CLR_CYCLES(CLRN), .INIT_HOLD(HOLD), .VLEN(32)
    ) u_par (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .fence_t_i(fence), .pc_commit_i(pc),
        .boot_addr_i(boot), .rst_addr_o(o_addr[0]),
        .ch_en_i(en), .ch(if_p),
        .time_irq_i(irq), .pad_i(pad),
        .ceil_o(o_ceil[0]), .ceil_valid_o(o_cv[0]),
        .halt_o(o_halt[0]), .clr_o(o_clr[0]),
        .init_no_o(o_ino[0]), .busy_o(o_busy[0])
    );

    fence_t_seq #(
        .NUM_CH(2), .SEQUENTIAL(1), .CNT_W(32),
        .CLR_CYCLES(CLRN), .INIT_HOLD(HOLD), .VLEN(32)
    ) u_seq (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .fence_t_i(fence), .pc_commit_i(pc),
        .boot_addr_i(boot), .rst_addr_o(o_addr[1]),
        .ch_en_i(en), .ch(if_s),
        .time_irq_i(irq), .pad_i(pad),
        .ceil_o(o_ceil[1]), .ceil_valid_o(o_cv[1]),
        .halt_o(o_halt[1]), .clr_o(o_clr[1]),
        .init_no_o(o_ino[1]), .busy_o(o_busy[1])
    );

    // model: phase 0 idle, 1 flushing, 2 draining, 3 clearing
    int          ph  [2];
    logic [1:0]  pend[2];
    int          cl  [2];
    int          hd  [2];
    logic [31:0] cnt [2];
    logic [31:0] ad  [2];
    bit          vld [2];
    bit          iq  [2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %0h want %0h", nm, a, e);
    endtask

    function automatic void m_reset(int m);
        ph[m] = 0; pend[m] = '0; cl[m] = 0; hd[m] = 0;
        cnt[m] = '0; ad[m] = '0; vld[m] = 0; iq[m] = 0;
    endfunction

    // parallel: every pending channel; sequential: lowest one
    function automatic logic [1:0] m_req(int m);
        logic [1:0] r = '0;
        if (ph[m] != 1) return '0;
        if (m == 0) return pend[m];
        for (int i = 0; i < 2; i++)
            if (pend[m][i] && r == '0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic compare();
        for (int m = 0; m < 2; m++) begin
            logic [1:0]  r    = m_req(m);
            logic [1:0]  left = pend[m] & ~(ack[m] & r);
            logic        cv   = (ph[m] == 1) && (left == '0);
            logic [31:0] ce   = (cv && cnt[m] != 0) ? pad - cnt[m] : '0;
            chk($sformatf("req%0d", m), 32'(o_req[m]), 32'(r));
            chk($sformatf("halt%0d", m), 32'(o_halt[m]), 32'(ph[m] != 0));
            chk($sformatf("busy%0d", m), 32'(o_busy[m]), 32'(ph[m] != 0));
            chk($sformatf("clr%0d", m), 32'(o_clr[m]), 32'(ph[m] == 3));
            chk($sformatf("ino%0d", m), 32'(o_ino[m]),
                32'(ph[m] == 3 || hd[m] > 0));
            chk($sformatf("cv%0d", m), 32'(o_cv[m]), 32'(cv));
            chk($sformatf("ceil%0d", m), o_ceil[m], ce);
            chk($sformatf("addr%0d", m), o_addr[m], vld[m] ? ad[m] : boot);
        end
    endtask

    function automatic void m_step(int m);
        logic [31:0] oc = cnt[m];
        logic [1:0]  r  = m_req(m);
        if (irq && !iq[m]) cnt[m] = pad;
        else if (cnt[m] != 0) cnt[m] = cnt[m] - 1;
        iq[m] = irq;
        if (hd[m] > 0) hd[m]--;
        case (ph[m])
            0: if (fence) begin
                ph[m] = 1; ad[m] = pc + 4; vld[m] = 1; pend[m] = en;
            end
            1: begin
                pend[m] = pend[m] & ~(ack[m] & r);
                if (pend[m] == '0) ph[m] = 2;
            end
            2: if (bz[m] == '0 && oc == 0) begin
                ph[m] = 3; cl[m] = CLRN;
            end
            default: begin
                cl[m]--;
                if (cl[m] == 0) begin ph[m] = 0; hd[m] = HOLD; end
            end
        endcase
    endfunction

    task automatic tick();
        #1;
        if (!rst_n) begin m_reset(0); m_reset(1); end
        compare();
        if (rst_n) begin
            for (int m = 0; m < 2; m++)
                if (clr) m_reset(m); else m_step(m);
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        int nclr;
        int nino;
        ack[0] = '0; ack[1] = '0; bz[0] = '0; bz[1] = '0;
        m_reset(0); m_reset(1);
        @(negedge clk);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_addr_lit", o_addr[0], 32'h0000_1000);
        chk("rst_halt_lit", 32'(o_halt[0]), 32'd0);

        // parallel + sequential ordering
        en = 2'b11; pc = 32'h8000_0100; fence = 1'b1;
        tick(); fence = 1'b0;
        chk("par_req_p1", 32'(o_req[0]), 32'h3);
        chk("seq_req_p1", 32'(o_req[1]), 32'h1);
        tick();
        ack[1] = 2'b10; tick(); ack[1] = '0;
        chk("seq_spur_p3", 32'(o_req[1]), 32'h1);
        ack[0] = 2'b01; ack[1] = 2'b01; tick();
        ack[0] = '0; ack[1] = '0;
        chk("par_req_p4", 32'(o_req[0]), 32'h2);
        chk("seq_req_p4", 32'(o_req[1]), 32'h2);
        tick();
        ack[0] = 2'b10; ack[1] = 2'b10; tick();
        ack[0] = '0; ack[1] = '0;
        chk("par_req_p6", 32'(o_req[0]), 32'h0);
        chk("addr_lit", o_addr[0], 32'h8000_0104);
        nclr = 0; nino = 0;
        repeat (40) begin
            if (o_clr[0]) nclr++;
            else if (nclr > 0 && o_ino[0]) nino++;
            tick();
        end
        chk("clr_len", nclr, CLRN);
        chk("ino_hold", nino, HOLD);

        // padding to timer boundary
        pad = 100; en = 2'b01; fence = 1'b1;
        tick(); fence = 1'b0;
        irq = 1'b1; tick();
        repeat (40) tick();
        ack[0] = 2'b01; ack[1] = 2'b01;
        #1;
        chk("pad_cv", 32'(o_cv[0]), 32'd1);
        chk("pad_ceil40", o_ceil[0], 32'd40);
        tick(); ack[0] = '0; ack[1] = '0;
        k = 1;
        while (!o_clr[0] && k < 200) begin tick(); k++; end
        chk("pad_wait", k, 61);
        irq = 1'b0;
        repeat (25) tick();

        // busy drain
        en = 2'b11; fence = 1'b1; tick(); fence = 1'b0;
        ack[0] = 2'b11; ack[1] = 2'b01; tick();
        ack[0] = '0; ack[1] = 2'b10; bz[0] = 2'b01;
        tick(); ack[1] = '0;
        repeat (9) tick();
        chk("drain_noclr", 32'(o_clr[0]), 32'd0);
        chk("drain_halt", 32'(o_halt[0]), 32'd1);
        bz[0] = '0; tick();
        chk("clr_after_busy", 32'(o_clr[0]), 32'd1);
        repeat (25) tick();

        // no channels enabled
        en = 2'b00; fence = 1'b1; tick(); fence = 1'b0;
        chk("skip_req", 32'(o_req[0]), 32'd0);
        #1 chk("skip_cv", 32'(o_cv[0]), 32'd1);
        tick(); tick();
        chk("skip_clr", 32'(o_clr[0]), 32'd1);

        // clr_i during CLR
        clr = 1'b1; tick(); clr = 1'b0;
        chk("clri_halt", 32'(o_halt[0]), 32'd0);
        chk("clri_ino", 32'(o_ino[0]), 32'd0);
        chk("clri_addr", o_addr[0], 32'h0000_1000);
        tick();

        // async reset mid-flush
        en = 2'b11; pc = 32'h4000_0000; fence = 1'b1;
        tick(); fence = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(o_req[0]), 32'd0);
        chk("arst_addr", o_addr[0], 32'h0000_1000);
        tick(); rst_n = 1'b1;
        nclr = 0;
        repeat (30) begin if (o_clr[0]) nclr++; tick(); end
        chk("arst_noclr", nclr, 0);

        // pc + 4 wraps
        pc = 32'hFFFF_FFFE; en = 2'b00; fence = 1'b1;
        tick(); fence = 1'b0;
        chk("wrap_addr", o_addr[0], 32'h0000_0002);
        repeat (25) tick();

        for (int i = 0; i < 3000; i++) begin
            rst_n = 1'b1;
            if ($urandom_range(699) == 0) rst_n = 1'b0;
            clr   = ($urandom_range(399) == 0);
            fence = ($urandom_range(7) == 0);
            pc    = $urandom;
            en    = 2'($urandom);
            pad   = $urandom_range(60);
            if ($urandom_range(19) == 0) irq = ~irq;
            for (int m = 0; m < 2; m++) begin
                ack[m] = m_req(m) & 2'($urandom);
                if ($urandom_range(7) == 0) ack[m] |= 2'($urandom);
                bz[m] = ($urandom_range(3) == 0) ? 2'($urandom) : 2'b00;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
